// File: rtl/instr_fetch.sv
// instr_fetch: owns the fetch PC, issues sequential word requests, buffers {pc, instr} in order for decode.
// Latency: a memory response becomes visible on inst_* one cycle later; redirect flushes the buffer next cycle.
// Backpressure: request held stable until imem_req_ready; decode stalls throttle requests through buffer credits.
// Optional feature macro FETCH_MISALIGN_CHK_EN: misaligned redirect halts fetch and emits one flagged entry.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        inst_misaligned
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Fetch PC and request bookkeeping
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;   // requests accepted but not yet answered
  logic [CNT_W-1:0] drop_q, drop_d;     // oldest outstanding responses to discard
  // PCs of live (non-dropped) outstanding requests, oldest first
  logic [31:0]      pcq_q [FIFO_DEPTH];
  logic [31:0]      pcq_d [FIFO_DEPTH];
  logic [PTR_W-1:0] pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
  // Instruction buffer towards decode
  logic [31:0]      buf_dat_q [FIFO_DEPTH];
  logic [31:0]      buf_dat_d [FIFO_DEPTH];
  logic [31:0]      buf_pc_q  [FIFO_DEPTH];
  logic [31:0]      buf_pc_d  [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        halted;
  logic        mis_push;
  logic [31:0] redir_pc;
  logic        credit_ok;
  logic        req_fire;
  logic        rsp_live;
  logic        rsp_keep;
  logic        buf_push;
  logic        buf_pop;

`ifdef FETCH_MISALIGN_CHK_EN
  logic halt_q, halt_d;
  logic pend_q, pend_d;   // flagged entry still to be written once drops finish
  logic redir_mis;

  assign redir_mis       = (redirect_pc[1:0] != 2'b00);
  assign redir_pc        = redirect_pc;
  assign halted          = halt_q;
  assign mis_push        = pend_q && (drop_q == '0);
  // While halted the buffer can only ever hold the single flagged entry
  assign inst_misaligned = halt_q && inst_valid;

  // Halt state register
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
      pend_q <= pend_d;
    end
  end
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign redir_pc            = {redirect_pc[31:2], 2'b00};
  assign halted              = 1'b0;
  assign mis_push            = 1'b0;
`endif

  // In-flight plus buffered never exceeds FIFO_DEPTH, so every response has a slot
  assign credit_ok      = ({1'b0, outst_q} + {1'b0, cnt_q}) < DEPTH_C;
  assign imem_req_valid = !rst && credit_ok && !redirect_valid && !halted;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding (e.g. left over from before reset) are ignored
  assign rsp_live = imem_rsp_valid && (outst_q != '0);
  assign rsp_keep = rsp_live && (drop_q == '0);
  assign buf_push = rsp_keep || mis_push;

  assign inst_valid = (cnt_q != '0);
  assign inst_data  = inst_valid ? buf_dat_q[rd_q] : 32'h0;
  assign inst_pc    = inst_valid ? buf_pc_q[rd_q]  : 32'h0;
  assign buf_pop    = inst_valid && inst_ready;

  // Next-state: redirect flushes everything and converts all outstanding requests into drops
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    pcq_d      = pcq_q;
    pq_rd_d    = pq_rd_q;
    pq_wr_d    = pq_wr_q;
    buf_dat_d  = buf_dat_q;
    buf_pc_d   = buf_pc_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
`ifdef FETCH_MISALIGN_CHK_EN
    halt_d     = halt_q;
    pend_d     = pend_q;
`endif
    if (redirect_valid) begin
      // No request can be accepted this cycle, only a response can retire
      outst_d    = outst_q - CNT_W'(rsp_live);
      drop_d     = outst_d;
      pq_rd_d    = '0;
      pq_wr_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
      fetch_pc_d = redir_pc;
`ifdef FETCH_MISALIGN_CHK_EN
      halt_d     = redir_mis;
      pend_d     = redir_mis;
`endif
    end else begin
      if (req_fire) begin
        fetch_pc_d       = fetch_pc_q + 32'd4;
        pcq_d[pq_wr_q]   = fetch_pc_q;
        pq_wr_d          = pq_wr_q + 1'b1;
      end
      outst_d = outst_q + CNT_W'(req_fire) - CNT_W'(rsp_live);
      if (rsp_live && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      if (rsp_keep) begin
        pq_rd_d = pq_rd_q + 1'b1;
      end
      if (buf_push) begin
        // Halted fetch_pc still holds the misaligned target
        buf_dat_d[wr_q] = rsp_keep ? imem_rsp_data : NOP_INSTR;
        buf_pc_d[wr_q]  = rsp_keep ? pcq_q[pq_rd_q] : fetch_pc_q;
        wr_d            = wr_q + 1'b1;
      end
      if (buf_pop) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + CNT_W'(buf_push) - CNT_W'(buf_pop);
`ifdef FETCH_MISALIGN_CHK_EN
      if (mis_push) begin
        pend_d = 1'b0;
      end
`endif
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      pq_rd_q    <= '0;
      pq_wr_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pcq_q[i]     <= 32'h0;
        buf_dat_q[i] <= 32'h0;
        buf_pc_q[i]  <= 32'h0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      pq_rd_q    <= pq_rd_d;
      pq_wr_q    <= pq_wr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      pcq_q      <= pcq_d;
      buf_dat_q  <= buf_dat_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

endmodule
